genie_split_ex: RTL and testbench

Packet-aware broadcast split node, the fan-out counterpart of the merge node. It takes one valid/ready/eop input stream with a per-packet destination mask and presents each beat to every selected output. Each beat is held until all selected outputs have accepted it, and outputs may accept on different cycles. It sits in the generated interconnect wherever one source drives several sinks.

---
 rtl/genie_split_pkg.sv | 9 +
 rtl/genie_split_ex_if.sv | 27 ++
 rtl/genie_split_ex.sv | 89 ++++++++
 tb/tb_genie_split_ex.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/genie_split_pkg.sv
// Shared types for the genie_split_ex broadcast split node.
package genie_split_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } state_t;

endpackage

// File: rtl/genie_split_ex_if.sv
// Upstream beat stream plus the NO downstream streams of the split node.
interface genie_split_ex_if #(
   parameter int unsigned NO    = 2,
   parameter int unsigned WIDTH = 1
);
   localparam int unsigned DW = (WIDTH == 0) ? 1 : WIDTH;

   logic                 i_valid;
   logic                 o_ready;
   logic [DW-1:0]        i_data;
   logic                 i_eop;
   logic [NO-1:0]        i_mask;
   logic [NO-1:0]        o_valid;
   logic [NO*DW-1:0]     o_data;
   logic [NO-1:0]        i_ready;
   logic [NO-1:0]        o_eop;

   modport master (
      output i_valid, i_data, i_eop, i_mask, i_ready,
      input  o_ready, o_valid, o_data, o_eop
   );

   modport slave (
      input  i_valid, i_data, i_eop, i_mask, i_ready,
      output o_ready, o_valid, o_data, o_eop
   );
endinterface

// File: rtl/genie_split_ex.sv
// Packet-aware broadcast split: each beat is held until every selected output
// has taken it; the destination mask is latched on the first beat of a packet.
module genie_split_ex
   import genie_split_pkg::*;
#(
   parameter int unsigned NO    = 2,
   parameter int unsigned WIDTH = 1
) (
   input logic             clk,
   input logic             reset,
   genie_split_ex_if.slave bus
);
   localparam int unsigned DW = (WIDTH == 0) ? 1 : WIDTH;

   if (NO < 2) begin : g_bad_no
      $error("genie_split_ex: NO must be at least 2");
   end

   state_t        r_st;
   state_t        w_st_nxt;
   logic [NO-1:0] r_pkt_mask;
   logic [NO-1:0] w_pkt_mask_nxt;
   logic [NO-1:0] r_done;
   logic [NO-1:0] w_done_nxt;
   logic [NO-1:0] w_eff_mask;
   logic [NO-1:0] w_o_valid;
   logic [NO-1:0] w_xfer_out;
   logic          w_o_ready;
   logic          w_in_xfer;

   assign w_eff_mask = (r_st == IDLE) ? bus.i_mask : r_pkt_mask;

   // An output is satisfied if unselected, already done, or ready now.
   assign w_o_ready = reset & (&(~w_eff_mask | r_done | bus.i_ready));
   assign w_in_xfer = bus.i_valid & w_o_ready;

   for (genvar k = 0; k < NO; k++) begin : g_out
      assign w_o_valid[k]  = reset & bus.i_valid & w_eff_mask[k] & ~r_done[k];
      assign w_xfer_out[k] = w_o_valid[k] & bus.i_ready[k];
      assign w_done_nxt[k] = w_in_xfer ? 1'b0 : (r_done[k] | w_xfer_out[k]);
   end

   assign bus.o_valid = w_o_valid;
   assign bus.o_ready = w_o_ready;
   assign bus.o_data  = {NO{bus.i_data}};
   assign bus.o_eop   = {NO{bus.i_eop}};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_st       <= IDLE;
         r_pkt_mask <= '0;
         r_done     <= '0;
      end else begin
         r_st       <= w_st_nxt;
         r_pkt_mask <= w_pkt_mask_nxt;
         r_done     <= w_done_nxt;
      end
   end

   always_comb begin
      w_st_nxt       = r_st;
      w_pkt_mask_nxt = r_pkt_mask;
      if (w_in_xfer) begin
         case (r_st)
            IDLE: begin
               if (!bus.i_eop) begin
                  w_st_nxt       = IN_PKT;
                  w_pkt_mask_nxt = bus.i_mask;
               end
            end
            IN_PKT: begin
               if (bus.i_eop) w_st_nxt = IDLE;
            end
            default: w_st_nxt = IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   // Once some output has taken a beat, upstream must keep it stable.
   a_hold: assert property (@(posedge clk) disable iff (!reset)
      (bus.i_valid && !w_o_ready && (r_done != '0)) |=>
      (bus.i_valid && $stable(bus.i_data) && $stable(bus.i_eop)));

   a_mask: assert property (@(posedge clk) disable iff (!reset)
      ((w_o_valid & ~w_eff_mask) == '0));
`endif

endmodule

// File: tb/tb_genie_split_ex.sv
// Directed and randomized checks of genie_split_ex (NO=4, WIDTH=8).
module tb_genie_split_ex;
   import genie_split_pkg::*;

   localparam int unsigned NO = 4;
   localparam int unsigned W  = 8;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   genie_split_ex_if #(.NO(NO), .WIDTH(W)) bus ();

   genie_split_ex #(.NO(NO), .WIDTH(W)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic e,
                        input logic [NO-1:0] m, input logic [NO-1:0] r);
      bus.i_valid = v;
      bus.i_data  = d;
      bus.i_eop   = e;
      bus.i_mask  = m;
      bus.i_ready = r;
   endtask

   // Scoreboard state for the soak
   logic [W:0] q [NO][$];
   int         exp_cnt [NO];
   int         obs_cnt [NO];

   initial begin
      logic [NO-1:0] mask;
      logic [NO-1:0] taken;
      logic [NO-1:0] exp_v;
      logic          exp_r;
      logic [W-1:0]  d;
      logic [W:0]    front;
      logic          accepted;
      int            len;
      int            idx;

      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(1'b1, 8'h11, 1'b1, 4'b1111, 4'b1111);
      #12;
      check("rst_valid", 64'(bus.o_valid), 64'(0));
      check("rst_ready", 64'(bus.o_ready), 64'(0));
      check("rst_st", 64'(dut.r_st), 64'(IDLE));
      drive(1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000);
      tick();
      rst_n = 1'b1;
      tick();

      // single beat, mask 0101, all ready
      drive(1'b1, 8'hA5, 1'b1, 4'b0101, 4'b1111);
      #4;
      check("t1_valid", 64'(bus.o_valid), 64'(4'b0101));
      check("t1_ready", 64'(bus.o_ready), 64'(1));
      check("t1_data2", 64'(bus.o_data[2*W +: W]), 64'(8'hA5));
      tick();
      drive(1'b0, 8'h00, 1'b0, 4'b0000, 4'b1111);
      #4;
      check("t1_idle_valid", 64'(bus.o_valid), 64'(0));
      check("t1_st", 64'(dut.r_st), 64'(IDLE));
      tick();

      // staggered acceptance, mask 0111
      drive(1'b1, 8'h3C, 1'b1, 4'b0111, 4'b0001);
      #4;
      check("t2_c0_valid", 64'(bus.o_valid), 64'(4'b0111));
      check("t2_c0_ready", 64'(bus.o_ready), 64'(0));
      tick();
      check("t2_done0", 64'(dut.r_done), 64'(4'b0001));
      bus.i_ready = 4'b0100;
      #4;
      check("t2_c1_valid", 64'(bus.o_valid), 64'(4'b0110));
      check("t2_c1_ready", 64'(bus.o_ready), 64'(0));
      tick();
      check("t2_done1", 64'(dut.r_done), 64'(4'b0101));
      bus.i_ready = 4'b0010;
      #4;
      check("t2_c2_valid", 64'(bus.o_valid), 64'(4'b0010));
      check("t2_c2_ready", 64'(bus.o_ready), 64'(1));
      tick();
      check("t2_done2", 64'(dut.r_done), 64'(0));
      drive(1'b0, 8'h00, 1'b0, 4'b0000, 4'b1111);
      tick();

      // 4-beat packet: mask latched on beat0, later masks ignored
      for (int b = 0; b < 4; b++) begin
         drive(1'b1, 8'(8'h40 + b), (b == 3), (b == 0) ? 4'b0010 : 4'b0001, 4'b1111);
         #4;
         check("t3_valid", 64'(bus.o_valid), 64'(4'b0010));
         check("t3_ready", 64'(bus.o_ready), 64'(1));
         tick();
         check("t3_st", 64'(dut.r_st), (b == 3) ? 64'(IDLE) : 64'(IN_PKT));
      end
      drive(1'b0, 8'h00, 1'b0, 4'b0000, 4'b1111);
      tick();

      // zero mask: discarded at full rate, FSM still tracks eop
      for (int b = 0; b < 2; b++) begin
         drive(1'b1, 8'(8'h70 + b), (b == 1), 4'b0000, 4'b0000);
         #4;
         check("t4_valid", 64'(bus.o_valid), 64'(0));
         check("t4_ready", 64'(bus.o_ready), 64'(1));
         tick();
         check("t4_st", 64'(dut.r_st), (b == 1) ? 64'(IDLE) : 64'(IN_PKT));
      end

      // reset mid-packet with partial done
      drive(1'b1, 8'h90, 1'b0, 4'b0011, 4'b1111);
      tick();
      drive(1'b1, 8'h91, 1'b0, 4'b0000, 4'b0001);
      #4;
      check("t5_stall", 64'(bus.o_ready), 64'(0));
      tick();
      check("t5_done", 64'(dut.r_done), 64'(4'b0001));
      check("t5_st", 64'(dut.r_st), 64'(IN_PKT));
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 64'(bus.o_valid), 64'(0));
      check("t5_rst_ready", 64'(bus.o_ready), 64'(0));
      check("t5_rst_st", 64'(dut.r_st), 64'(IDLE));
      tick();
      rst_n = 1'b1;
      drive(1'b1, 8'h92, 1'b1, 4'b0010, 4'b1111);
      #4;
      check("t5_new_valid", 64'(bus.o_valid), 64'(4'b0010));
      check("t5_new_ready", 64'(bus.o_ready), 64'(1));
      tick();
      drive(1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000);
      tick();

      // randomized soak against a per-output beat queue
      for (int k = 0; k < NO; k++) begin
         exp_cnt[k] = 0;
         obs_cnt[k] = 0;
      end
      idx  = 0;
      len  = 0;
      mask = '0;
      for (int beat = 0; beat < 10000; beat++) begin
         if (idx == 0) begin
            len  = $urandom_range(1, 4);
            mask = NO'($urandom);
         end
         if ($urandom_range(0, 3) == 0) begin
            bus.i_valid = 1'b0;
            tick();
         end
         d = W'($urandom);
         drive(1'b1, d, (idx == len - 1), (idx == 0) ? mask : NO'($urandom), '0);
         for (int k = 0; k < NO; k++) begin
            if (mask[k]) begin
               q[k].push_back({bus.i_eop, d});
               exp_cnt[k]++;
            end
         end
         taken    = '0;
         accepted = 1'b0;
         for (int c = 0; c < 200 && !accepted; c++) begin
            bus.i_ready = NO'($urandom);
            if (idx != 0) bus.i_mask = NO'($urandom);
            #4;
            exp_v = mask & ~taken;
            exp_r = &(~mask | taken | bus.i_ready);
            check("soak_valid", 64'(bus.o_valid), 64'(exp_v));
            check("soak_ready", 64'(bus.o_ready), 64'(exp_r));
            for (int k = 0; k < NO; k++) begin
               if (bus.o_valid[k] && bus.i_ready[k]) begin
                  obs_cnt[k]++;
                  if (q[k].size() == 0) begin
                     check("soak_extra_beat", 64'(k), 64'(NO));
                  end else begin
                     front = q[k].pop_front();
                     check("soak_payload", 64'({bus.o_eop[k], bus.o_data[k*W +: W]}), 64'(front));
                  end
               end
            end
            accepted = bus.o_ready;
            taken    = taken | (bus.o_valid & bus.i_ready);
            tick();
         end
         if (!accepted) check("soak_timeout", 64'(beat), 64'(-1));
         idx = (idx == len - 1) ? 0 : idx + 1;
      end
      bus.i_valid = 1'b0;
      tick();
      for (int k = 0; k < NO; k++) begin
         check("soak_count", 64'(obs_cnt[k]), 64'(exp_cnt[k]));
         check("soak_q_empty", 64'(q[k].size()), 64'(0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
